// File: rtl/color_encode.sv
// color_encode: RGB565 pixel to nearest 5-bit palette code.
// Walks the 19-entry palette one entry per cycle, keeps the minimum.
module color_encode #(
  parameter int EXACT_EXIT = 1,
  parameter int RB_SHIFT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_code,
  output logic        out_exact
);

  localparam int DMAX = 2 * ((31 * 31) << RB_SHIFT) + 63 * 63;
  localparam int DW   = $clog2(DMAX + 1);
  localparam logic [4:0] LAST = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]   r_rgb;
  logic [4:0]    r_idx;
  logic [DW-1:0] r_best_dist;
  logic [4:0]    r_best_code;
  logic          r_out_valid;
  logic [4:0]    r_out_code;
  logic          r_out_exact;

  logic [15:0]   w_pal;
  logic [4:0]    w_code;
  logic [4:0]    w_dr;
  logic [5:0]    w_dg;
  logic [4:0]    w_db;
  logic [9:0]    w_dr2;
  logic [11:0]   w_dg2;
  logic [9:0]    w_db2;
  logic [DW-1:0] w_dist;
  logic          w_less;
  logic          w_hit;
  logic          w_last;
  logic          w_exit;

  function automatic logic [15:0] pal_rgb(input logic [4:0] i);
    logic [15:0] v;
    case (i)
      5'd0:    v = 16'h0000;
      5'd1:    v = 16'hf800;
      5'd2:    v = 16'h07e0;
      5'd3:    v = 16'h001f;
      5'd4:    v = 16'h000f;
      5'd5:    v = 16'h03e0;
      5'd6:    v = 16'h03ef;
      5'd7:    v = 16'h7800;
      5'd8:    v = 16'h780f;
      5'd9:    v = 16'h7be0;
      5'd10:   v = 16'hc618;
      5'd11:   v = 16'h7bef;
      5'd12:   v = 16'h07ff;
      5'd13:   v = 16'hf81f;
      5'd14:   v = 16'hffe0;
      5'd15:   v = 16'hfd20;
      5'd16:   v = 16'hf81f;
      5'd17:   v = 16'hafe5;
      default: v = 16'hffff;
    endcase
    return v;
  endfunction

  assign w_pal  = pal_rgb(r_idx);
  assign w_code = (r_idx == LAST) ? 5'h1f : r_idx;

  assign w_dr = (r_rgb[15:11] >= w_pal[15:11]) ?
                (r_rgb[15:11] - w_pal[15:11]) :
                (w_pal[15:11] - r_rgb[15:11]);
  assign w_dg = (r_rgb[10:5] >= w_pal[10:5]) ?
                (r_rgb[10:5] - w_pal[10:5]) :
                (w_pal[10:5] - r_rgb[10:5]);
  assign w_db = (r_rgb[4:0] >= w_pal[4:0]) ?
                (r_rgb[4:0] - w_pal[4:0]) :
                (w_pal[4:0] - r_rgb[4:0]);

  assign w_dr2 = {5'd0, w_dr} * {5'd0, w_dr};
  assign w_dg2 = {6'd0, w_dg} * {6'd0, w_dg};
  assign w_db2 = {5'd0, w_db} * {5'd0, w_db};

  assign w_dist = (DW'(w_dr2) << RB_SHIFT) +
                  DW'(w_dg2) +
                  (DW'(w_db2) << RB_SHIFT);

  // strict compare keeps the lowest position on a tie
  assign w_less = (w_dist < r_best_dist);
  assign w_hit  = (EXACT_EXIT != 0) && (w_dist == '0);
  assign w_last = (r_idx == LAST);
  assign w_exit = w_last || w_hit;

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = S_SEARCH;
      S_SEARCH: if (w_exit) w_next = S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // search datapath and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb       <= '0;
      r_idx       <= '0;
      r_best_dist <= '1;
      r_best_code <= '0;
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_exact <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rgb       <= in_rgb;
            r_idx       <= '0;
            r_best_dist <= '1;
            r_best_code <= '0;
          end
        end
        S_SEARCH: begin
          if (w_less) begin
            r_best_dist <= w_dist;
            r_best_code <= w_code;
          end
          if (w_exit) begin
            r_out_valid <= 1'b1;
            r_out_code  <= w_less ? w_code : r_best_code;
            r_out_exact <= w_less ? (w_dist == '0) :
                                    (r_best_dist == '0);
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;
  assign out_exact = r_out_exact;

endmodule
